jzjpcc_regfile_sb: RTL

Parametrised integer register file for the pipelined core, replacing the fixed two-read, one-write regfile.
- Configurable data width, register count and number of read ports.
- Write-to-read bypass in the same cycle.
- Hardwired zero register.
- Pending-write scoreboard: decode reserves a destination, writeback releases it, and the block reports read-after-write hazards plus an aggregate stall.
- Sits between decode (read/reserve) and writeback (write).

---
 rtl/jzjpcc_pkg.sv | 11 +
 rtl/jzjpcc_scoreboard.sv | 61 ++++++
 rtl/jzjpcc_regfile_sb.sv | 74 +++++++
 3 files changed

// File: rtl/jzjpcc_pkg.sv
// Shared core types: default datapath/regfile sizes and the register-address
// and word types used by the decode and writeback stages.
package jzjpcc_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [$clog2(NUM_REGS)-1:0] regAddr_t;
  typedef logic [XLEN-1:0]             word_t;

endpackage

// File: rtl/jzjpcc_scoreboard.sv
// Pending-write scoreboard: decode reserves a destination, writeback releases
// it. Reports per-port busy flags and a registered count of pending registers.
module jzjpcc_scoreboard #(
  parameter int unsigned NUM_REGS = jzjpcc_pkg::NUM_REGS,
  parameter int unsigned NUM_READ = 2,
  localparam int unsigned AW = $clog2(NUM_REGS),
  localparam int unsigned CW = $clog2(NUM_REGS + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_READ*AW-1:0]   rsAddr,
  input  logic [AW-1:0]            rdAddr,
  input  logic                     rdWriteEn,
  input  logic [AW-1:0]            reserveAddr,
  input  logic                     reserveEn,
  input  logic                     flush,
  output logic [NUM_READ-1:0]      rsBusy,
  output logic [CW-1:0]            pendingCount
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_d;

  // Release first, then reserve, so a younger producer keeps the register.
  always_comb begin
    pend_d  = pend_q;
    count_d = '0;
    if (flush) begin
      pend_d = '0;
    end else begin
      if (rdWriteEn) pend_d[rdAddr] = 1'b0;
      if (reserveEn) pend_d[reserveAddr] = 1'b1;
    end
    pend_d[0] = 1'b0;
    for (int n = 0; n < NUM_REGS; n++) begin
      count_d = count_d + CW'(pend_d[n]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  assign pendingCount = count_q;

  // A same-cycle writeback to the read register is resolved by the bypass.
  for (genvar i = 0; i < NUM_READ; i++) begin : g_busy
    logic [AW-1:0] addr;
    assign addr      = rsAddr[i*AW +: AW];
    assign rsBusy[i] = pend_q[addr] & ~(rdWriteEn & (rdAddr == addr));
  end

endmodule

// File: rtl/jzjpcc_regfile_sb.sv
// Parametrised integer register file with write-to-read bypass, hardwired
// zero register and a pending-write scoreboard for RAW hazard stalls.
module jzjpcc_regfile_sb #(
  parameter int unsigned XLEN     = jzjpcc_pkg::XLEN,
  parameter int unsigned NUM_REGS = jzjpcc_pkg::NUM_REGS,
  parameter int unsigned NUM_READ = 2,
  localparam int unsigned AW = $clog2(NUM_REGS),
  localparam int unsigned CW = $clog2(NUM_REGS + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_READ*AW-1:0]   rsAddr,
  input  logic [NUM_READ-1:0]      rsUsed,
  output logic [NUM_READ*XLEN-1:0] rs,
  output logic [NUM_READ-1:0]      rsBusy,
  output logic                     stall,
  input  logic [AW-1:0]            rdAddr,
  input  logic [XLEN-1:0]          rd,
  input  logic                     rdWriteEn,
  input  logic [AW-1:0]            reserveAddr,
  input  logic                     reserveEn,
  input  logic                     flush,
  output logic [CW-1:0]            pendingCount
);

  logic [XLEN-1:0] mem [NUM_REGS];
  logic            wr_ok;

  assign wr_ok = rdWriteEn & (rdAddr != '0);

  // Entry 0 is never written and stays at its reset value of zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        mem[n] <= '0;
      end
    end else if (wr_ok) begin
      mem[rdAddr] <= rd;
    end
  end

  // Bypass is suppressed during reset so every port reads zero.
  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [AW-1:0] addr;
    assign addr = rsAddr[i*AW +: AW];
    always_comb begin
      rs[i*XLEN +: XLEN] = mem[addr];
      if (addr == '0) begin
        rs[i*XLEN +: XLEN] = '0;
      end else if (rdWriteEn && !reset && (rdAddr == addr)) begin
        rs[i*XLEN +: XLEN] = rd;
      end
    end
  end

  jzjpcc_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_READ (NUM_READ)
  ) u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .rsAddr       (rsAddr),
    .rdAddr       (rdAddr),
    .rdWriteEn    (rdWriteEn),
    .reserveAddr  (reserveAddr),
    .reserveEn    (reserveEn),
    .flush        (flush),
    .rsBusy       (rsBusy),
    .pendingCount (pendingCount)
  );

  assign stall = |(rsBusy & rsUsed);

endmodule
